// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - single-stage branch target/condition resolver with valid/ready handshake
// Optional statistics counters (stat_clr, br_cnt, tk_cnt) are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int SHIFT     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     p4,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]     rs_val,
  input  logic [WIDTH-1:0]     rt_val,
  input  logic [1:0]           br_type,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     target,
  output logic [WIDTH-1:0]     next_pc,
  output logic                 taken,
`ifdef BRANCH_STATS_EN
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] br_cnt,
  output logic [CNT_WIDTH-1:0] tk_cnt,
`endif
  output logic                 wrap
);

  localparam logic [1:0] BR_BEQ  = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_UNC  = 2'b10;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] next_pc_q, next_pc_d;
  logic             taken_q, taken_d;
  logic             wrap_q, wrap_d;

  logic             accept;
  logic [WIDTH-1:0] offset;
  logic [WIDTH:0]   sum;
  logic             cond;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // The carry out of the unsigned WIDTH+1-bit sum, compared with the offset sign, flags modular wrap.
  always_comb begin
    offset = WIDTH'($signed(imm)) << SHIFT;
    sum    = {1'b0, p4} + {1'b0, offset};
    case (br_type)
      BR_BEQ:  cond = (rs_val == rt_val);
      BR_BNE:  cond = (rs_val != rt_val);
      BR_UNC:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    target_d  = target_q;
    next_pc_d = next_pc_q;
    taken_d   = taken_q;
    wrap_d    = wrap_q;
    if (accept) begin
      valid_d   = 1'b1;
      target_d  = sum[WIDTH-1:0];
      next_pc_d = cond ? sum[WIDTH-1:0] : p4;
      taken_d   = cond;
      wrap_d    = sum[WIDTH] ^ offset[WIDTH-1];
    end else if (out_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      target_q  <= '0;
      next_pc_q <= '0;
      taken_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      target_q  <= target_d;
      next_pc_q <= next_pc_d;
      taken_q   <= taken_d;
      wrap_q    <= wrap_d;
    end
  end

  assign out_valid = valid_q;
  assign target    = target_q;
  assign next_pc   = next_pc_q;
  assign taken     = taken_q;
  assign wrap      = wrap_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] tk_cnt_q, tk_cnt_d;

  // Clear wins over a same-cycle increment; counters wrap naturally.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (stat_clr) begin
      br_cnt_d = '0;
      tk_cnt_d = '0;
    end else if (accept) begin
      if (br_type != 2'b11) br_cnt_d = br_cnt_q + 1'b1;
      if (cond)             tk_cnt_d = tk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign br_cnt = br_cnt_q;
  assign tk_cnt = tk_cnt_q;
`else
  // CNT_WIDTH only sizes the statistics counters, which are absent in this build.
  if (CNT_WIDTH < 1) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

`ifdef BRANCH_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] p4, rs_val, rt_val;
  logic [15:0] imm;
  logic [1:0]  br_type;
  logic        out_valid, out_ready;
  logic [31:0] target, next_pc;
  logic        taken, wrap;
`ifdef BRANCH_STATS_EN
  logic          stat_clr;
  logic [CW-1:0] br_cnt, tk_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .IMM_WIDTH(16), .SHIFT(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .p4(p4), .imm(imm), .rs_val(rs_val), .rt_val(rt_val), .br_type(br_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .target(target), .next_pc(next_pc), .taken(taken),
`ifdef BRANCH_STATS_EN
    .stat_clr(stat_clr), .br_cnt(br_cnt), .tk_cnt(tk_cnt),
`endif
    .wrap(wrap)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [31:0] a, input logic [15:0] i,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [1:0] bt);
    in_valid = 1'b1; p4 = a; imm = i; rs_val = rs; rt_val = rt; br_type = bt;
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] i,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [1:0] bt);
    set_req(a, i, rs, rt, bt);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] t, input logic [31:0] n,
                           input logic tk, input logic w);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_target"}, target, t);
    check({tag, "_next_pc"}, next_pc, n);
    check({tag, "_taken"}, taken, tk);
    check({tag, "_wrap"}, wrap, w);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    p4 = '0; imm = '0; rs_val = '0; rt_val = '0; br_type = 2'b00;
`ifdef BRANCH_STATS_EN
    stat_clr = 1'b0;
`endif
    #22;
    check("rst_valid", out_valid, 0);
    check("rst_target", target, 0);
    check("rst_next_pc", next_pc, 0);
    check("rst_taken", taken, 0);
    check("rst_wrap", wrap, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rel_in_ready", in_ready, 1);

    issue(32'h104, 16'h0003, 5, 5, 2'b00);
    check_res("beq_fwd", 32'h110, 32'h110, 1, 0);
    issue(32'h100, 16'hFFFF, 7, 7, 2'b01);
    check_res("bne_back", 32'hFC, 32'h100, 0, 0);
    issue(32'hFFFFFFFC, 16'h0002, 0, 0, 2'b10);
    check_res("wrap_pos", 32'h4, 32'h4, 1, 1);
    issue(32'h4, 16'hFFFE, 0, 0, 2'b10);
    check_res("wrap_neg", 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 1);
    issue(32'h200, 16'h0001, 3, 3, 2'b11);
    check_res("reserved", 32'h204, 32'h200, 0, 0);
    issue(32'h300, 16'h0010, 1, 2, 2'b01);
    check_res("bne_ne", 32'h340, 32'h340, 1, 0);

    // drain with no request; garbage inputs while in_valid is low must be ignored
    p4 = 32'hDEAD0000; imm = 16'h1234; br_type = 2'b10;
    @(posedge clk); #1;
    check("drain_valid", out_valid, 0);
    check("idle_target_hold", target, 32'h340);

    // backpressure
    out_ready = 1'b0;
    issue(32'h1000, 16'h0001, 9, 9, 2'b00);
    check_res("bp_first", 32'h1004, 32'h1004, 1, 0);
    set_req(32'h2000, 16'h0002, 0, 0, 2'b10);
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_target", target, 32'h1004);
      check("bp_hold_taken", taken, 1);
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check_res("bp_second", 32'h2008, 32'h2008, 1, 0);
    for (int i = 0; i < 4; i++) begin
      set_req(32'h3000 + 32'(i) * 32'h10, 16'(i), 0, 0, 2'b10);
      @(posedge clk); #1;
      check("stream_valid", out_valid, 1);
      check("stream_target", target, 32'h3000 + 32'(i) * 32'h14);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_end_valid", out_valid, 0);

    // reset while a result is held under backpressure
    out_ready = 1'b0;
    issue(32'h5000, 16'h0004, 0, 0, 2'b10);
    check("pre_rst_valid", out_valid, 1);
    #2; rst = 1'b1; #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_target", target, 0);
    check("async_rst_next_pc", next_pc, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_ready", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("no_stale_valid", out_valid, 0);
    end
    out_ready = 1'b1;

`ifdef BRANCH_STATS_EN
    check("stat_rst_br", br_cnt, 0);
    check("stat_rst_tk", tk_cnt, 0);
    issue(32'h100, 16'h1, 1, 1, 2'b00);
    issue(32'h100, 16'h1, 2, 2, 2'b00);
    issue(32'h100, 16'h1, 1, 2, 2'b00);
    issue(32'h100, 16'h1, 1, 1, 2'b11);
    issue(32'h100, 16'h1, 0, 0, 2'b10);
    check("stat_br", br_cnt, 4);
    check("stat_tk", tk_cnt, 3);
    stat_clr = 1'b1;
    issue(32'h100, 16'h1, 0, 0, 2'b10);
    stat_clr = 1'b0;
    check("stat_clr_br", br_cnt, 0);
    check("stat_clr_tk", tk_cnt, 0);
    for (int i = 0; i < 15; i++) issue(32'h100, 16'h1, 0, 0, 2'b10);
    check("stat_ones_br", br_cnt, 4'hF);
    check("stat_ones_tk", tk_cnt, 4'hF);
    issue(32'h100, 16'h1, 0, 0, 2'b10);
    check("stat_wrap_br", br_cnt, 0);
    check("stat_wrap_tk", tk_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
